// File: rtl/iobus_i2c_pkg.sv
// Shared types and register map for the memory-mapped I2C master.
// Field positions here are the single source for both the CTRL decode and the STATUS read mux.
package iobus_i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StBits,
    StAck,
    StStop
  } i2c_state_e;

  localparam logic [31:0] CtrlOffset   = 32'h0;
  localparam logic [31:0] StatusOffset = 32'h4;

  localparam int unsigned CtrlStartBit = 8;
  localparam int unsigned CtrlStopBit  = 9;
  localparam int unsigned CtrlReadBit  = 10;
  localparam int unsigned CtrlNackBit  = 11;

  localparam int unsigned StatBusyBit   = 0;
  localparam int unsigned StatAckErrBit = 1;
  localparam int unsigned StatRxLsb     = 8;

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-period timer: strobes the first and last cycle of each SCL quarter.
// While hold_i is high the count freezes and neither strobe fires.
module i2c_qtick #(
  parameter int unsigned QDIV = 125
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic hold_i,
  output logic qstart_o,
  output logic qend_o
);

  localparam int unsigned CntW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(QDIV - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (!en_i) begin
      cnt_q <= '0;
    end else if (!hold_i) begin
      cnt_q <= (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    end
  end

  assign qstart_o = en_i && !hold_i && (cnt_q == '0);
  assign qend_o   = en_i && !hold_i && (cnt_q == CntMax);

endmodule

// File: rtl/iobus_i2c_master.sv
// Memory-mapped single-byte I2C master (CTRL at BASE_ADDR, STATUS at BASE_ADDR+4).
// Define I2C_STRETCH_EN to let a target stretch SCL; otherwise SCL_IN is ignored.
module iobus_i2c_master
  import iobus_i2c_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
  parameter int unsigned QDIV      = 125
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        SCL_OE,
  output logic        SDA_OE,
  input  logic        SCL_IN,
  input  logic        SDA_IN
);

  i2c_state_e state_q;
  logic [1:0] qtr_q;
  logic [2:0] bit_q;
  logic [7:0] sh_q;
  logic [7:0] rxdata_q;
  logic       ack_err_q, busy_q, scl_oe_q, sda_oe_q;
  logic       stop_q, read_q, nack_q;
  logic       accept, qstart, qend, stretch_hold;

  logic unused_wdata;
  assign unused_wdata = ^IOBUS_OUT[31:12];

  assign accept = IOBUS_WR && (IOBUS_ADDR == BASE_ADDR + CtrlOffset) && !busy_q;

`ifdef I2C_STRETCH_EN
  // A target holding SCL low after we released it pauses the quarter timer.
  assign stretch_hold = !scl_oe_q && !SCL_IN;
`else
  logic unused_scl_in;
  assign unused_scl_in = SCL_IN;
  assign stretch_hold  = 1'b0;
`endif

  i2c_qtick #(
    .QDIV(QDIV)
  ) u_qtick (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .en_i    (busy_q),
    .hold_i  (stretch_hold),
    .qstart_o(qstart),
    .qend_o  (qend)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= StIdle;
      qtr_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      rxdata_q  <= '0;
      ack_err_q <= 1'b0;
      busy_q    <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
      stop_q    <= 1'b0;
      read_q    <= 1'b0;
      nack_q    <= 1'b0;
    end else if (state_q == StIdle) begin
      if (accept) begin
        state_q   <= IOBUS_OUT[CtrlStartBit] ? StStart : StBits;
        busy_q    <= 1'b1;
        ack_err_q <= 1'b0;
        sh_q      <= IOBUS_OUT[7:0];
        stop_q    <= IOBUS_OUT[CtrlStopBit];
        read_q    <= IOBUS_OUT[CtrlReadBit];
        nack_q    <= IOBUS_OUT[CtrlNackBit];
        qtr_q     <= '0;
        bit_q     <= '0;
      end
    end else begin
      // Pin actions are taken on the first cycle of each quarter.
      if (qstart) begin
        case (state_q)
          StStart: begin
            case (qtr_q)
              2'd0: begin
                scl_oe_q <= 1'b0;
                sda_oe_q <= 1'b0;
              end
              2'd1:    sda_oe_q <= 1'b1;
              2'd3:    scl_oe_q <= 1'b1;
              default: ;
            endcase
          end
          StBits: begin
            case (qtr_q)
              2'd0:    sda_oe_q <= !read_q && !sh_q[7];
              2'd1:    scl_oe_q <= 1'b0;
              2'd2:    sh_q     <= {sh_q[6:0], SDA_IN};
              default: scl_oe_q <= 1'b1;
            endcase
          end
          StAck: begin
            case (qtr_q)
              2'd0: sda_oe_q <= read_q && !nack_q;
              2'd1: scl_oe_q <= 1'b0;
              2'd2: begin
                if (!read_q) ack_err_q <= SDA_IN;
              end
              default: scl_oe_q <= 1'b1;
            endcase
          end
          StStop: begin
            case (qtr_q)
              2'd0:    sda_oe_q <= 1'b1;
              2'd1:    scl_oe_q <= 1'b0;
              2'd2:    sda_oe_q <= 1'b0;
              default: ;
            endcase
          end
          default: ;
        endcase
      end
      if (qend) begin
        qtr_q <= qtr_q + 2'd1;
        if (qtr_q == 2'd3) begin
          case (state_q)
            StStart: begin
              state_q <= StBits;
              bit_q   <= '0;
            end
            StBits: begin
              bit_q <= bit_q + 3'd1;
              if (bit_q == 3'd7) state_q <= StAck;
            end
            StAck: begin
              if (read_q) rxdata_q <= sh_q;
              if (stop_q) begin
                state_q <= StStop;
              end else begin
                state_q  <= StIdle;
                busy_q   <= 1'b0;
                sda_oe_q <= 1'b0;
              end
            end
            StStop: begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    IOBUS_IN = '0;
    if (IOBUS_ADDR == BASE_ADDR + StatusOffset) begin
      IOBUS_IN[StatBusyBit]        = busy_q;
      IOBUS_IN[StatAckErrBit]      = ack_err_q;
      IOBUS_IN[StatRxLsb +: 8]     = rxdata_q;
    end
  end

  assign SCL_OE = scl_oe_q;
  assign SDA_OE = sda_oe_q;

endmodule

// File: tb/tb_iobus_i2c_master.sv
// Randomised bench for iobus_i2c_master with an open-drain bus and a simple byte target model.
module tb_iobus_i2c_master;

  localparam logic [31:0] Base       = 32'h1100_0100;
  localparam logic [31:0] StatusAddr = Base + 32'h4;
  localparam int unsigned Qdiv       = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr, wdata, rdata;
  logic        wr;
  logic        scl_oe, sda_oe, scl_bus, sda_bus;
  logic        stretch_low = 1'b0;
  logic        tgt_low;

  int   n_checks = 0;
  int   n_pass   = 0;

  bit       cur_read = 0, cur_start = 0, tgt_ack = 1;
  logic [7:0] tgt_byte = 8'h00;
  int       drv_slot = -1, rise_cnt = 0, starts = 0, stops = 0;
  bit       rec[$];
  logic     scl_prev = 1'b1, sda_prev = 1'b1;

  logic [7:0] rx_model = 8'h00;
  bit       ackerr_model = 0;
  bit       scl_held = 0;

  always #5 clk = ~clk;

  assign scl_bus = !scl_oe && !stretch_low;
  assign sda_bus = !sda_oe && !tgt_low;

  // Target drives read data in slots 0..7 and its ACK in slot 8 of a write.
  always_comb begin
    tgt_low = 1'b0;
    if (cur_read && drv_slot >= 0 && drv_slot < 8) tgt_low = !tgt_byte[7-drv_slot];
    else if (!cur_read && drv_slot == 8) tgt_low = tgt_ack;
  end

  iobus_i2c_master #(
    .BASE_ADDR(Base),
    .QDIV     (Qdiv)
  ) dut (
    .CLK       (clk),
    .RESET     (rst),
    .IOBUS_ADDR(addr),
    .IOBUS_OUT (wdata),
    .IOBUS_WR  (wr),
    .IOBUS_IN  (rdata),
    .SCL_OE    (scl_oe),
    .SDA_OE    (sda_oe),
    .SCL_IN    (scl_bus),
    .SDA_IN    (sda_bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Bus monitor: SDA value at every SCL rise, plus START/STOP conditions.
  always @(negedge clk) begin
    if (scl_bus && !scl_prev) begin
      rec.push_back(sda_bus);
      rise_cnt++;
    end
    if (!scl_bus && scl_prev) drv_slot = rise_cnt;
    if (scl_bus && scl_prev && sda_prev && !sda_bus && cur_start) begin
      starts++;
      rec.delete();
      rise_cnt = 0;
    end
    if (scl_bus && scl_prev && !sda_prev && sda_bus) stops++;
    scl_prev = scl_bus;
    sda_prev = sda_bus;
  end

  task automatic run_xfer(input logic [11:0] cmd, input logic [7:0] tbyte, input bit tack,
                          input bit inject, input bit stretch);
    int exp_q, exp_dur, dur, inj_k, limit, st_phase, st_cnt;
    logic [7:0] got_byte, exp_byte;
    bit exp_slot;
    exp_q   = (cmd[8] ? 4 : 0) + 36 + (cmd[9] ? 4 : 0);
    exp_dur = exp_q * Qdiv + (stretch ? 300 : 0);
    inj_k   = 2 + int'($urandom_range(exp_q * Qdiv - 6));
    @(negedge clk);
    cur_read  = cmd[10];
    cur_start = cmd[8];
    tgt_byte  = tbyte;
    tgt_ack   = tack;
    rec.delete();
    rise_cnt = 0;
    starts   = 0;
    stops    = 0;
    drv_slot = cmd[8] ? -1 : 0;
    addr     = Base;
    wdata    = {20'h0, cmd};
    wr       = 1'b1;
    dur      = -1;
    st_phase = 0;
    st_cnt   = 0;
    limit    = exp_dur + 64;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (inject && k == inj_k) begin
        addr  = Base;
        wdata = $urandom;
        wr    = 1'b1;
      end else begin
        addr = StatusAddr;
        wr   = 1'b0;
      end
      if (stretch) begin
        case (st_phase)
          0: if (drv_slot == 2) begin
            stretch_low = 1'b1;
            st_phase    = 1;
          end
          1: if (!scl_oe) begin
            st_cnt   = 0;
            st_phase = 2;
          end
          2: begin
            st_cnt++;
            if (st_cnt == 300) begin
              stretch_low = 1'b0;
              st_phase    = 3;
            end
          end
          default: ;
        endcase
      end
      @(posedge clk);
      #1;
      if (addr == StatusAddr && rdata[0] == 1'b0) begin
        dur = k;
        break;
      end
    end
    wr          = 1'b0;
    stretch_low = 1'b0;
    check_eq("busy_cycles", dur, exp_dur);
    check_eq("scl_rises", rec.size(), 9 + int'(cmd[9]));
    got_byte = 8'h00;
    for (int i = 0; i < 8 && i < rec.size(); i++) got_byte[7-i] = rec[i];
    exp_byte = cmd[10] ? tbyte : cmd[7:0];
    check_eq("data_bits", got_byte, exp_byte);
    exp_slot = cmd[10] ? cmd[11] : !tack;
    if (rec.size() > 8) check_eq("ack_slot", rec[8], exp_slot);
    if (cmd[8]) check_eq("start_cond", starts, 1);
    check_eq("stop_cond", stops, int'(cmd[9]));
    if (cmd[10]) begin
      rx_model     = tbyte;
      ackerr_model = 0;
    end else begin
      ackerr_model = !tack;
    end
    @(negedge clk);
    addr = StatusAddr;
    #1;
    check_eq("status", rdata, {16'h0, rx_model, 6'h0, ackerr_model, 1'b0});
    scl_held = !cmd[9];
  endtask

  initial begin
    logic [11:0] cmd;
    bit          hit;
    addr  = StatusAddr;
    wdata = 32'h0;
    wr    = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_status", rdata, 32'h0);
    check_eq("rst_scl_oe", scl_oe, 1'b0);
    check_eq("rst_sda_oe", sda_oe, 1'b0);
    @(negedge clk);
    rst  = 1'b0;
    addr = Base;
    #1;
    check_eq("ctrl_read_zero", rdata, 32'h0);
    @(negedge clk);
    addr  = Base + 32'h8;
    wdata = 32'h3A4;
    wr    = 1'b1;
    @(negedge clk);
    wr   = 1'b0;
    addr = StatusAddr;
    #1;
    check_eq("other_addr_wr", rdata, 32'h0);

    run_xfer(12'h3A4, 8'h00, 1'b1, 1'b0, 1'b0);
    run_xfer(12'h3A4, 8'h00, 1'b0, 1'b0, 1'b0);
    run_xfer(12'h1C3, 8'h00, 1'b1, 1'b0, 1'b0);
    run_xfer(12'hE00, 8'h5C, 1'b1, 1'b0, 1'b0);
    run_xfer(12'h3A4, 8'h00, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of bit 3 of an all-zero write.
    @(negedge clk);
    cur_read  = 0;
    cur_start = 1;
    tgt_ack   = 1;
    tgt_byte  = 8'h00;
    rec.delete();
    rise_cnt = 0;
    drv_slot = -1;
    addr     = Base;
    wdata    = 32'h100;
    wr       = 1'b1;
    @(negedge clk);
    wr   = 1'b0;
    addr = StatusAddr;
    hit  = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (drv_slot == 3 && scl_oe && sda_oe) begin
        hit = 1;
        break;
      end
    end
    check_eq("bit3_reached", hit, 1'b1);
    repeat (Qdiv) @(negedge clk);
    check_eq("bit3_scl_low", scl_oe, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("midrst_scl_oe", scl_oe, 1'b0);
    check_eq("midrst_sda_oe", sda_oe, 1'b0);
    check_eq("midrst_status", rdata, 32'h0);
    rx_model     = 8'h00;
    ackerr_model = 0;
    scl_held     = 0;
    @(negedge clk);
    rst = 1'b0;

`ifdef I2C_STRETCH_EN
    run_xfer(12'h35A, 8'h00, 1'b1, 1'b0, 1'b1);
`endif

    for (int t = 0; t < 16; t++) begin
      cmd[7:0] = 8'($urandom);
      cmd[8]   = scl_held ? 1'($urandom) : 1'b1;
      cmd[9]   = 1'($urandom);
      cmd[10]  = 1'($urandom);
      cmd[11]  = 1'($urandom);
      run_xfer(cmd, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/iobus_i2c_master.md
IOBUS_I2C_MASTER -- requirements
Module: iobus_i2c_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1100_0100, which is the byte address of the CTRL register; STATUS is at BASE_ADDR+4.
REQ-002 SHALL have parameter QDIV, default 125, which is the number of CLK cycles per quarter SCL period (50 MHz -> 100 kHz).
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port IOBUS_ADDR  input  32  CPU MMIO address.
REQ-006 SHALL have port IOBUS_OUT  input  32  CPU write data.
REQ-007 SHALL have port IOBUS_WR  input  1  CPU write strobe, valid for one cycle.
REQ-008 SHALL have port IOBUS_IN  output  32  read data returned to the CPU.
REQ-009 SHALL have port SCL_OE  output  1  1 = drive SCL low, 0 = release SCL.
REQ-010 SHALL have port SDA_OE  output  1  1 = drive SDA low, 0 = release SDA.
REQ-011 SHALL have port SCL_IN  input  1  sampled SCL pad level.
REQ-012 SHALL have port SDA_IN  input  1  sampled SDA pad level.

Function
REQ-013 SHALL accept a command in the CTRL write cycle, when IOBUS_WR=1, IOBUS_ADDR=BASE_ADDR and busy=0; CTRL fields: [7:0] TXDATA, [8] START, [9] STOP, [10] READ, [11] NACK.
REQ-014 SHALL set busy on the edge after a command is accepted and clear it on the edge on which the FSM returns to IDLE.
REQ-015 SHALL ignore CTRL writes while busy=1; the command is dropped and no state changes.
REQ-016 SHALL ignore writes to any address other than BASE_ADDR.
REQ-017 SHALL drive IOBUS_IN combinationally: when IOBUS_ADDR=BASE_ADDR+4, IOBUS_IN = {16'b0, rxdata[7:0], 6'b0, ack_err, busy}; at any other address, IOBUS_IN = 0.
REQ-018 SHALL implement the FSM states IDLE, START, BITS, ACK and STOP; each state step spans 4 quarter ticks (q0..q3) generated every QDIV cycles.
REQ-019 SHALL route IDLE -> START on an accepted command with START=1, and IDLE -> BITS on an accepted command with START=0.
REQ-020 SHALL perform START as: q0 release SDA and SCL, q1 drive SDA low, q2 hold, q3 drive SCL low; then go to BITS.
REQ-021 SHALL perform BITS as 8 bits, MSB first; per bit: q0 set SDA (write: TXDATA bit; read: release), q1 release SCL, q2 sample SDA_IN into the shift register on a read, q3 drive SCL low.
REQ-022 SHALL perform ACK as one bit: on a write, SDA is released and the q2 sample is stored in ack_err (1 = NACK); on a read, SDA is driven with the NACK bit, low for ACK.
REQ-023 SHALL transfer the shifted byte to rxdata at the end of ACK on a read; rxdata holds its value otherwise.
REQ-024 SHALL go ACK -> STOP if STOP=1, else ACK -> IDLE with SCL held low and SDA released.
REQ-025 SHALL perform STOP as: q0 drive SDA low, q1 release SCL, q2 release SDA, q3 hold; then go to IDLE.
REQ-026 SHALL clear ack_err when a new command is accepted; it is sticky until then.
REQ-027 SHALL keep the quarter counter at 0 in IDLE so that q0 begins on the cycle after acceptance.

Reset
REQ-028 SHALL on RESET immediately set state=IDLE, busy=0, ack_err=0, rxdata=0, SCL_OE=0 and SDA_OE=0, including when a transfer is in progress.
REQ-029 SHALL reset the quarter counter and bit counter to 0.

Configuration
REQ-030 SHALL, with I2C_STRETCH_EN defined, hold the quarter counter while SCL is released and SCL_IN=0, supporting target clock stretching.
REQ-031 SHALL, without I2C_STRETCH_EN defined, ignore SCL_IN and time quarters from QDIV alone.

Structure
REQ-032 SHALL place the state enum, the CTRL/STATUS offsets and the bit positions in package iobus_i2c_pkg.
REQ-033 SHALL implement the quarter-tick divider, with its stretch hold input, as sub-module i2c_qtick.

Verification
REQ-034 SHALL cover: write 0x3A4 (START|STOP, data 0xA4) with the target ACKing -> SDA shows 1,0,1,0,0,1,0,0 on SCL rises, followed by a stop, busy=0 and ack_err=0 after 44 quarters.
REQ-035 SHALL cover: the same write with SDA_IN held high in the ACK slot -> STATUS read = 0x00000002.
REQ-036 SHALL cover: write 0xE00 (READ|STOP|NACK) with the target returning 0x5C -> STATUS read = 0x00005C00 and SDA released in the ACK slot.
REQ-037 SHALL cover: a second CTRL write while busy=1 -> ignored, and the bit sequence is unchanged.
REQ-038 SHALL cover: RESET asserted during bit 3 -> SCL_OE=0, SDA_OE=0 and busy=0 in the same cycle.
REQ-039 SHALL cover, with I2C_STRETCH_EN defined: SCL_IN held low for 300 cycles during a q1 -> the bit is extended by 300 cycles with no sample lost.
